// File: rtl/pixel_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_frame_writer_pkg
// Purpose  : Frame geometry, bus widths and writer state encoding shared by
//            the ingest-side writer and the read-side address decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pixel_frame_writer_pkg;

    // Detection window geometry, row-major, one word per pixel
    localparam int DEF_IMG_W   = 66;
    localparam int DEF_IMG_H   = 130;
    localparam int FRAME_PIX   = DEF_IMG_W * DEF_IMG_H;   // 8580
    localparam int DEF_PIX_W   = 8;
    localparam int DEF_ADDR_W  = 15;                      // covers 2 banks

    // Writer state encoding
    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_STALL = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pixel_addr_counter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_addr_counter
// Purpose  : Raster position tracker. Holds column, row and linear offset of
//            the next pixel inside one frame. Usable by writer and reader.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_clear       - return to position 0 (applied before advance)
//            i_advance     - step to the next raster position
//            o_lin         - linear offset inside the frame
//            o_last        - current position is the last pixel of the frame
// Revision : 1.0 - initial release
// ============================================================================
module pixel_addr_counter
    import pixel_frame_writer_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int LIN_W = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [LIN_W-1:0] o_lin,
    output logic             o_last
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] r_col, w_col_base, w_col_nxt;
    logic [ROW_W-1:0] r_row, w_row_base, w_row_nxt;
    logic [LIN_W-1:0] r_lin, w_lin_base, w_lin_nxt;

    // Clear and advance together leave the counter at position 1, which is
    // what a start-of-frame pixel written at position 0 needs.
    always_comb begin
        w_col_base = i_clear ? '0 : r_col;
        w_row_base = i_clear ? '0 : r_row;
        w_lin_base = i_clear ? '0 : r_lin;
        w_col_nxt  = w_col_base;
        w_row_nxt  = w_row_base;
        w_lin_nxt  = w_lin_base;
        if (i_advance) begin
            w_lin_nxt = w_lin_base + LIN_W'(1);
            if (w_col_base == c_col_last) begin
                w_col_nxt = '0;
                w_row_nxt = (w_row_base == c_row_last) ? '0 : w_row_base + ROW_W'(1);
            end else begin
                w_col_nxt = w_col_base + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
            r_lin <= '0;
        end else begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
            r_lin <= w_lin_nxt;
        end
    end

    assign o_lin  = r_lin;
    assign o_last = (r_col == c_col_last) && (r_row == c_row_last);

endmodule
`default_nettype wire

// File: rtl/pixel_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_frame_writer
// Purpose  : Writes a raster pixel stream into a two-bank pixel RAM and hands
//            completed banks to the read side (double buffering).
// Ports    : iClk, iRst            - clock, synchronous active-high reset
//            iValid/oReady/iSof    - pixel stream handshake, start of frame
//            iPixel                - pixel value
//            oWrEn/oWrAddr/oWrData - registered RAM write port
//            oFrameDone            - pulse when a bank is completed
//            oRdValid/oRdBank      - oldest completed bank owned by reader
//            iRelease              - reader done with oRdBank
//            oErr                  - pulse on a framing error
// Revision : 1.0 - initial release
// ============================================================================
module pixel_frame_writer
    import pixel_frame_writer_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iSof,
    input  logic [PIX_W-1:0]  iPixel,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [PIX_W-1:0]  oWrData,
    output logic              oFrameDone,
    output logic              oRdValid,
    output logic              oRdBank,
    input  logic              iRelease,
    output logic              oErr
);

    localparam logic [ADDR_W-1:0] c_bank1_base = ADDR_W'(IMG_W * IMG_H);

    state_t            r_state, w_state_nxt;
    logic              r_wb, w_wb_nxt;
    logic [1:0]        r_full_cnt, w_full_nxt;
    logic              r_rd_bank, w_rd_bank_nxt;
    logic              r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [PIX_W-1:0]  r_wr_data, w_wr_data_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;

    logic              w_ready, w_xfer, w_rel, w_complete;
    logic              w_cnt_clear, w_cnt_adv, w_cnt_last;
    logic [ADDR_W-1:0] w_cnt_lin, w_bank_base;

    pixel_addr_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .LIN_W (ADDR_W)
    ) u_addr_cnt (
        .clk       (iClk),
        .rst       (iRst),
        .i_clear   (w_cnt_clear),
        .i_advance (w_cnt_adv),
        .o_lin     (w_cnt_lin),
        .o_last    (w_cnt_last)
    );

    assign w_ready     = (r_state != ST_STALL);
    assign w_xfer      = iValid && w_ready;
    // A release with no bank owned by the reader is ignored.
    assign w_rel       = iRelease && (r_full_cnt != 2'd0);
    assign w_bank_base = r_wb ? c_bank1_base : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_wb_nxt      = r_wb;
        w_rd_bank_nxt = r_rd_bank ^ w_rel;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_cnt_clear   = 1'b0;
        w_cnt_adv     = 1'b0;
        w_complete    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (iSof) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = w_bank_base;
                        w_wr_data_nxt = iPixel;
                        w_cnt_clear   = 1'b1;
                        w_cnt_adv     = 1'b1;
                        w_state_nxt   = ST_FILL;
                    end else begin
                        w_err_nxt = 1'b1;           // pixel dropped
                    end
                end
            end
            ST_FILL: begin
                if (w_xfer) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_data_nxt = iPixel;
                    if (iSof) begin
                        // Restart the frame in the same bank.
                        w_wr_addr_nxt = w_bank_base;
                        w_err_nxt     = 1'b1;
                        w_cnt_clear   = 1'b1;
                        w_cnt_adv     = 1'b1;
                    end else begin
                        w_wr_addr_nxt = w_bank_base + w_cnt_lin;
                        if (w_cnt_last) begin
                            w_complete  = 1'b1;
                            w_cnt_clear = 1'b1;
                        end else begin
                            w_cnt_adv = 1'b1;
                        end
                    end
                end
            end
            ST_STALL: begin
                if (w_rel) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Completion and release in the same cycle cancel in the count.
        w_full_nxt = r_full_cnt + {1'b0, w_complete} - {1'b0, w_rel};
        if (w_complete) begin
            w_wb_nxt    = ~r_wb;
            w_done_nxt  = 1'b1;
            w_state_nxt = (w_full_nxt == 2'd2) ? ST_STALL : ST_IDLE;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state    <= ST_IDLE;
            r_wb       <= 1'b0;
            r_full_cnt <= 2'd0;
            r_rd_bank  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wb       <= w_wb_nxt;
            r_full_cnt <= w_full_nxt;
            r_rd_bank  <= w_rd_bank_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign oReady     = w_ready;
    assign oWrEn      = r_wr_en;
    assign oWrAddr    = r_wr_addr;
    assign oWrData    = r_wr_data;
    assign oFrameDone = r_done;
    assign oRdValid   = (r_full_cnt != 2'd0);
    assign oRdBank    = r_rd_bank;
    assign oErr       = r_err;

endmodule
`default_nettype wire
